// File: rtl/sha256_wsched_if.sv
// Handshake bundle between message source, SHA-256 schedule generator and round stage.
// SHA256_WSCHED_LAST_EN adds out_last, flagging the final round word of a block.
interface sha256_wsched_if;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] w_out;
  logic [7:0]  t_out;
  logic        out_ready;
`ifdef SHA256_WSCHED_LAST_EN
  logic        out_last;

  modport master (output in_valid, in_word, out_ready,
                  input  in_ready, out_valid, w_out, t_out, out_last);
  modport slave  (input  in_valid, in_word, out_ready,
                  output in_ready, out_valid, w_out, t_out, out_last);
`else
  modport master (output in_valid, in_word, out_ready,
                  input  in_ready, out_valid, w_out, t_out);
  modport slave  (input  in_valid, in_word, out_ready,
                  output in_ready, out_valid, w_out, t_out);
`endif
endinterface

// File: rtl/sha256_wsched.sv
// SHA-256 message schedule: loads 16 words, then streams W[0..63] with a 16-word sliding window.
// Optional SHA256_WSCHED_LAST_EN adds out_last on the t=63 word.
module sha256_wsched (
  input  logic           clk,
  input  logic           rst,
  sha256_wsched_if.slave bus
);
  typedef enum logic {LOAD, EMIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] win [16];
  logic [3:0]  load_cnt;
  logic [5:0]  round_cnt;
  logic        accept;
  logic        advance;
  logic [31:0] next_word;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // The window always holds W[t..t+15], so the appended word is W[t+16].
  assign next_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    case (state)
      LOAD: begin
        accept = bus.in_valid;
        if (accept && load_cnt == 4'd15) state_nxt = EMIT;
      end
      EMIT: begin
        advance = bus.out_ready;
        if (advance && round_cnt == 6'd63) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Both counters wrap to zero on their final step, which clears them for the next block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      load_cnt  <= 4'd0;
      round_cnt <= 6'd0;
      for (int i = 0; i < 16; i++) win[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept || advance) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= accept ? bus.in_word : next_word;
      end
      if (accept)  load_cnt  <= load_cnt + 4'd1;
      if (advance) round_cnt <= round_cnt + 6'd1;
    end
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == EMIT);
  assign bus.w_out     = win[0];
  assign bus.t_out     = {2'b00, round_cnt};
`ifdef SHA256_WSCHED_LAST_EN
  assign bus.out_last  = (state == EMIT) && (round_cnt == 6'd63);
`endif
endmodule
